// File: rtl/axi_dma_copy.sv
// Descriptor-driven AXI4 copy engine: read burst -> local buffer -> write burst -> B, repeated.
// Strictly one AXI channel active at a time; every valid holds its payload until ready.
module axi_dma_copy #(
    parameter int MAX_BURST_BEATS = 16,
    parameter int LEN_W           = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [63:0]      cmd_src,
    input  logic [63:0]      cmd_dst,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             m_axi_awvalid,
    input  logic             m_axi_awready,
    output logic [63:0]      m_axi_awaddr,
    output logic [7:0]       m_axi_awlen,
    output logic [2:0]       m_axi_awsize,
    output logic             m_axi_wvalid,
    input  logic             m_axi_wready,
    output logic [255:0]     m_axi_wdata,
    output logic [31:0]      m_axi_wstrb,
    output logic             m_axi_wlast,
    input  logic             m_axi_bvalid,
    output logic             m_axi_bready,
    output logic             m_axi_arvalid,
    input  logic             m_axi_arready,
    output logic [63:0]      m_axi_araddr,
    output logic [7:0]       m_axi_arlen,
    output logic [2:0]       m_axi_arsize,
    input  logic             m_axi_rvalid,
    output logic             m_axi_rready,
    input  logic [255:0]     m_axi_rdata,
    input  logic             m_axi_rlast
);
    localparam int         IW   = (MAX_BURST_BEATS > 1) ? $clog2(MAX_BURST_BEATS) : 1;
    localparam logic [8:0] MAXB = 9'(MAX_BURST_BEATS);

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_DONE} state_t;

    state_t           r_state, w_next;
    logic [63:0]      r_src, r_dst;
    logic [LEN_W-1:0] r_beats_left;
    logic [8:0]       r_burst, r_cnt;
    logic             r_err;
    logic [255:0]     r_buf [MAX_BURST_BEATS];

    logic             w_desc_bad, w_last_beat;
    logic [LEN_W-1:0] w_cmd_beats, w_left_after;
    logic [7:0]       w_len8;
    logic [63:0]      w_step;

    function automatic logic [8:0] f_burst(input logic [LEN_W-1:0] beats);
        return (beats > LEN_W'(MAX_BURST_BEATS)) ? MAXB : beats[8:0];
    endfunction

    assign w_desc_bad   = (cmd_len == '0) || (cmd_len[4:0] != 5'd0) ||
                          (cmd_src[4:0] != 5'd0) || (cmd_dst[4:0] != 5'd0);
    assign w_cmd_beats  = cmd_len >> 5;
    assign w_left_after = r_beats_left - LEN_W'(r_burst);
    assign w_last_beat  = (r_cnt == r_burst - 9'd1);
    assign w_len8       = (r_burst == 9'd0) ? 8'd0 : 8'(r_burst - 9'd1);
    assign w_step       = {50'd0, r_burst, 5'd0};

    always_comb begin
        w_next        = r_state;
        cmd_ready     = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        err           = r_err;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_wlast   = 1'b0;
        m_axi_wdata   = '0;
        m_axi_bready  = 1'b0;
        m_axi_araddr  = r_src;
        m_axi_awaddr  = r_dst;
        m_axi_arlen   = w_len8;
        m_axi_awlen   = w_len8;
        m_axi_arsize  = 3'd5;
        m_axi_awsize  = 3'd5;
        m_axi_wstrb   = 32'hFFFF_FFFF;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid && !w_desc_bad) w_next = S_AR;
            end
            S_AR: begin
                busy          = 1'b1;
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) w_next = S_R;
            end
            S_R: begin
                busy         = 1'b1;
                m_axi_rready = 1'b1;
                if (m_axi_rvalid && w_last_beat) w_next = S_AW;
            end
            S_AW: begin
                busy          = 1'b1;
                m_axi_awvalid = 1'b1;
                if (m_axi_awready) w_next = S_W;
            end
            S_W: begin
                busy         = 1'b1;
                m_axi_wvalid = 1'b1;
                m_axi_wlast  = w_last_beat;
                m_axi_wdata  = r_buf[r_cnt[IW-1:0]];
                if (m_axi_wready && w_last_beat) w_next = S_B;
            end
            S_B: begin
                busy         = 1'b1;
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) w_next = (w_left_after == '0) ? S_DONE : S_AR;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_src        <= '0;
            r_dst        <= '0;
            r_beats_left <= '0;
            r_burst      <= '0;
            r_cnt        <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (w_desc_bad) begin
                            r_err <= 1'b1;
                        end else begin
                            r_src        <= cmd_src;
                            r_dst        <= cmd_dst;
                            r_beats_left <= w_cmd_beats;
                            r_burst      <= f_burst(w_cmd_beats);
                        end
                    end
                end
                S_AR: r_cnt <= '0;
                S_R:  if (m_axi_rvalid) r_cnt <= w_last_beat ? 9'd0 : r_cnt + 9'd1;
                S_W:  if (m_axi_wready) r_cnt <= w_last_beat ? 9'd0 : r_cnt + 9'd1;
                S_B: begin
                    if (m_axi_bvalid) begin
                        r_src        <= r_src + w_step;
                        r_dst        <= r_dst + w_step;
                        r_beats_left <= w_left_after;
                        r_burst      <= f_burst(w_left_after);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_R && m_axi_rvalid) r_buf[r_cnt[IW-1:0]] <= m_axi_rdata;
    end

    // Beat counting alone ends the burst; rlast is only cross-checked here.
    always_ff @(posedge clk) begin
        if (!rst && r_state == S_R && m_axi_rvalid) assert (m_axi_rlast == w_last_beat);
    end
endmodule

// File: tb/tb_axi_dma_copy.sv
// Bench for axi_dma_copy: randomized AXI slave with a word-addressed memory and a copy-level reference.
module tb_axi_dma_copy;
    localparam int MAXB = 16;

    logic         clk = 1'b0, rst = 1'b1;
    logic         cmd_valid = 0, cmd_ready;
    logic [63:0]  cmd_src = '0, cmd_dst = '0;
    logic [31:0]  cmd_len = '0;
    logic         busy, done, err;
    logic         m_axi_awvalid, m_axi_awready = 0;
    logic [63:0]  m_axi_awaddr, m_axi_araddr;
    logic [7:0]   m_axi_awlen, m_axi_arlen;
    logic [2:0]   m_axi_awsize, m_axi_arsize;
    logic         m_axi_wvalid, m_axi_wready = 0, m_axi_wlast;
    logic [255:0] m_axi_wdata, m_axi_rdata = '0;
    logic [31:0]  m_axi_wstrb;
    logic         m_axi_bvalid = 0, m_axi_bready;
    logic         m_axi_arvalid, m_axi_arready = 0;
    logic         m_axi_rvalid = 0, m_axi_rready, m_axi_rlast = 0;

    axi_dma_copy #(.MAX_BURST_BEATS(MAXB), .LEN_W(32)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
        .busy(busy), .done(done), .err(err),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
        .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
        .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
        .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
        .m_axi_rlast(m_axi_rlast)
    );

    always #5 clk = ~clk;

    int              n_chk = 0, n_fail = 0;
    longint unsigned cyc = 0, last_lat = 0;
    bit              fast = 0;
    logic [255:0]    mem     [longint unsigned];
    logic [255:0]    ref_mem [longint unsigned];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int dly();
        return fast ? 0 : int'($urandom_range(0, 3));
    endfunction

    function automatic logic [255:0] rd(input longint unsigned a);
        return mem.exists(a) ? mem[a] : '0;
    endfunction

    function automatic logic [255:0] rref(input longint unsigned a);
        return ref_mem.exists(a) ? ref_mem[a] : '0;
    endfunction

    task automatic fill(input longint unsigned a, input int beats);
        logic [255:0] w;
        for (int i = 0; i < beats; i++) begin
            w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            mem[a + 64'(i) * 32]     = w;
            ref_mem[a + 64'(i) * 32] = w;
        end
    endtask

    task automatic serve_read(input longint unsigned a, input int len8);
        int n;
        n = 0;
        while (!m_axi_arvalid && n < 100) begin tick(); n++; end
        chk("arvalid", m_axi_arvalid, 1);
        chk("araddr", m_axi_araddr, a);
        chk("arlen", m_axi_arlen, len8);
        chk("arsize", m_axi_arsize, 5);
        chk("ar_aw_excl", {m_axi_awvalid, m_axi_wvalid}, 0);
        repeat (dly()) begin
            tick();
            chk("ar_hold", {m_axi_arvalid, m_axi_araddr, m_axi_arlen}, {1'b1, a, 8'(len8)});
        end
        m_axi_arready = 1; tick(); m_axi_arready = 0;
        for (int i = 0; i <= len8; i++) begin
            repeat (dly()) tick();
            m_axi_rvalid = 1;
            m_axi_rdata  = rd(a + 64'(i) * 32);
            m_axi_rlast  = (i == len8);
            chk("rready", m_axi_rready, 1);
            tick();
            m_axi_rvalid = 0; m_axi_rlast = 0;
        end
    endtask

    task automatic serve_write(input longint unsigned a, input int len8, input int abort_at, output bit aborted);
        int n, i;
        bit hold;
        logic [255:0] held;
        aborted = 0; n = 0; i = 0; hold = 0; held = '0;
        while (!m_axi_awvalid && n < 100) begin tick(); n++; end
        chk("awvalid", m_axi_awvalid, 1);
        chk("awaddr", m_axi_awaddr, a);
        chk("awlen", m_axi_awlen, len8);
        chk("awsize", m_axi_awsize, 5);
        chk("aw_ar_excl", m_axi_arvalid, 0);
        repeat (dly()) begin
            tick();
            chk("aw_hold", {m_axi_awvalid, m_axi_awaddr, m_axi_awlen}, {1'b1, a, 8'(len8)});
        end
        m_axi_awready = 1; tick(); m_axi_awready = 0;
        n = 0;
        while (i <= len8 && n < 400) begin
            if (i == abort_at) begin
                m_axi_wready = 0;
                rst = 1; #1;
                chk("rst_valids", {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready}, 0);
                tick();
                chk("rst_state", {cmd_ready, busy, done, err, m_axi_wvalid}, 5'b10000);
                rst = 0;
                aborted = 1;
                return;
            end
            m_axi_wready = fast ? 1'b1 : ($urandom_range(0, 2) != 0);
            chk("wvalid", m_axi_wvalid, 1);
            if (hold) chk("w_hold", m_axi_wdata, held);
            if (m_axi_wready) begin
                chk("wdata", m_axi_wdata, rref(a + 64'(i) * 32));
                chk("wlast", m_axi_wlast, i == len8);
                chk("wstrb", m_axi_wstrb, 32'hFFFF_FFFF);
                mem[a + 64'(i) * 32] = m_axi_wdata;
                i++;
                hold = 0;
            end else begin
                hold = 1;
                held = m_axi_wdata;
            end
            tick();
            n++;
        end
        m_axi_wready = 0;
        chk("w_beats", i, len8 + 1);
    endtask

    task automatic serve_b();
        chk("bready", m_axi_bready, 1);
        repeat (dly()) begin tick(); chk("b_wait", {m_axi_bready, done}, 2'b10); end
        m_axi_bvalid = 1; tick(); m_axi_bvalid = 0;
    endtask

    task automatic run_desc(input longint unsigned src, input longint unsigned dst, input int unsigned len,
                            input int abort_at);
        longint unsigned s, d, t0;
        int beats, burst;
        bit bad, ab;
        s = src; d = dst;
        bad = (len == 0) || (len % 32 != 0) || (src % 32 != 0) || (dst % 32 != 0);
        cmd_src = src; cmd_dst = dst; cmd_len = len; cmd_valid = 1;
        chk("cmd_ready_pre", cmd_ready, 1);
        tick();
        cmd_valid = 0;
        t0 = cyc;
        if (bad) begin
            chk("err_pulse", err, 1);
            chk("rej_ready", cmd_ready, 1);
            chk("rej_busy", busy, 0);
            tick();
            chk("err_clear", err, 0);
            chk("rej_novalid", {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, cmd_ready}, 4'b0001);
            return;
        end
        chk("acc_state", {busy, cmd_ready, err, done}, 4'b1000);
        beats = len / 32;
        for (int i = 0; i < beats; i++) ref_mem[dst + 64'(i) * 32] = rref(src + 64'(i) * 32);
        while (beats > 0) begin
            burst = (beats > MAXB) ? MAXB : beats;
            serve_read(s, burst - 1);
            serve_write(d, burst - 1, abort_at, ab);
            if (ab) return;
            serve_b();
            s += 64'(burst) * 32;
            d += 64'(burst) * 32;
            beats -= burst;
            if (beats > 0) chk("no_early_done", done, 0);
        end
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        last_lat = cyc - t0;
        tick();
        chk("done_clear", done, 0);
        chk("idle_ready", {cmd_ready, busy}, 2'b10);
        for (int i = 0; i < int'(len / 32); i++)
            chk("dst_data", rd(dst + 64'(i) * 32), rref(dst + 64'(i) * 32));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        longint unsigned rs, rdst;
        int nb;
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", {cmd_ready, busy, done, err}, 4'b1000);
        chk("rst_valids", {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready, m_axi_wlast}, 0);
        chk("rst_addr", {m_axi_araddr, m_axi_awaddr, m_axi_arlen, m_axi_awlen}, 0);
        chk("rst_size", {m_axi_arsize, m_axi_awsize}, 6'o55);
        chk("rst_wstrb", m_axi_wstrb, 32'hFFFF_FFFF);
        chk("rst_wdata", m_axi_wdata, 0);
        rst = 0;
        tick();

        fast = 1;
        fill(64'h1000, 1);
        run_desc(64'h1000, 64'h2000, 32, -1);
        chk("latency_le10", last_lat <= 10, 1);

        fast = 0;
        fill(64'h10000, 40);
        run_desc(64'h10000, 64'h20000, 1280, -1);

        run_desc(64'h1000, 64'h2000, 48, -1);
        run_desc(64'h1004, 64'h2000, 32, -1);
        run_desc(64'h1000, 64'h2000, 0, -1);
        run_desc(64'h1000, 64'h2010, 64, -1);

        fill(64'h30000, 4);
        run_desc(64'h30000, 64'h8000_0000_0000, 128, -1);
        run_desc(64'h8000_0000_0000, 64'h40000, 128, -1);
        for (int i = 0; i < 4; i++)
            chk("sram_roundtrip", rd(64'h40000 + 64'(i) * 32), rd(64'h30000 + 64'(i) * 32));

        fill(64'h50000, 8);
        run_desc(64'h50000, 64'h60000, 256, 2);
        chk("abort_no_done", {done, busy, cmd_ready}, 3'b001);
        run_desc(64'h50000, 64'h70000, 256, -1);

        for (int k = 0; k < 8; k++) begin
            nb   = int'($urandom_range(1, 40));
            rs   = 64'h100000 + 64'(k) * 64'h10000;
            rdst = 64'h900000 + 64'(k) * 64'h10000;
            fill(rs, nb);
            run_desc(rs, rdst, 32'(nb * 32), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
